rftpu_result_drain: RTL and testbench
=====================================

Name: rftpu_result_drain

Overview:
- Consumer end of the systolic array result interface.
- Captures each wide result vector (one cycle of result_valid, no backpressure) into a small vector FIFO.
- Serializes vectors lane by lane onto a narrow valid/ready stream toward the host/DMA.
- Counts drained vectors and signals completion when the programmed vector count has fully drained.

Parameters:
ARRAY_DIM, 16, lanes per result vector.
ACC_WIDTH, 32, bits per lane (accumulator width).
FIFO_DEPTH, 4, result vectors buffered; power of two, >= 2.

Ports:
clk  input  1  clock.
rst  input  1  synchronous active-high reset.
start  input  1  one-cycle pulse; flushes the FIFO, clears counters, enters RUN.
expected_vectors  input  16  vectors to drain; sampled on start.
result_valid  input  1  result vector present this cycle.
result_data  input  ARRAY_DIM*ACC_WIDTH  result vector; lane k = bits [k*ACC_WIDTH +: ACC_WIDTH].
almost_full  output  1  FIFO occupancy >= FIFO_DEPTH-1; upstream uses it to stall activations.
out_valid  output  1  output beat valid.
out_ready  input  1  downstream accepts the beat.
out_data  output  ACC_WIDTH  current lane value.
out_lane  output  $clog2(ARRAY_DIM)  index of the current lane.
out_last  output  1  high on lane ARRAY_DIM-1.
vec_count  output  16  vectors fully drained since start.
overflow  output  1  sticky; a result arrived while the FIFO was full.
done  output  1  one-cycle pulse when vec_count reaches the latched expected count.
checksum  output  ACC_WIDTH  see Optional Feature.

Behaviour:
- Reset (rst=1 at the clock edge): state IDLE, FIFO empty, lane pointer 0. All outputs 0: out_valid, out_data, out_lane, out_last, vec_count, overflow, done, almost_full, checksum.
- States:
  - IDLE: result_valid is ignored.
  - start -> RUN.
  - RUN: drained count == expected -> DONE.
  - DONE: start -> RUN.
  - start in any state (including mid-stream in RUN): flush FIFO, lane=0, out_valid=0, vec_count=0, overflow=0, checksum=0, latch expected_vectors. Any result_valid in the start cycle is discarded.
- Capture:
  - In RUN, result_valid with FIFO not full writes the vector.
  - With FIFO full and no pop that cycle, the vector is dropped and overflow is set.
  - With FIFO full and a pop in the same cycle, the push is accepted and overflow stays unchanged.
- Output presentation:
  - out_valid, out_data, out_lane and out_last are combinational from the FIFO head and lane pointer.
  - Head vector written at edge T -> out_valid high during cycle T+1.
  - Lane 0 is presented first.
  - While out_valid=1 and out_ready=0, all output fields hold stable.
- Handshake: beat transfers when out_valid && out_ready at an edge.
  - Lane < ARRAY_DIM-1: lane increments.
  - Lane ARRAY_DIM-1: lane wraps to 0, FIFO pops, vec_count increments.
- Back-to-back: with out_ready held high, a vector drains in exactly ARRAY_DIM cycles, and the next vector's lane 0 follows with no gap.
- Completion:
  - When the pop brings vec_count to the expected count, done pulses in the next cycle and state -> DONE.
  - expected_vectors=0: done pulses in the cycle after start, then DONE.
- DONE: result_valid sets overflow (unexpected extra vector) and is not stored. out_valid=0.
- vec_count saturates at 16'hFFFF.
- almost_full is registered from occupancy after the edge's push/pop.

Optional Feature:
- Macro: RESULT_CHECKSUM_EN.
- Defined: checksum accumulates the sum, modulo 2^ACC_WIDTH, of every transferred out_data beat; it is cleared on rst and on start.
- Undefined: checksum is constant 0 and no adder is synthesized.

Test Plan:
- Basic drain: ARRAY_DIM=16, start with expected=1; one vector with lane k = k+1; out_ready=1 -> 16 beats with out_data 1..16 and out_lane 0..15; out_last on beat 16; vec_count=1; done pulses once; checksum=136 with RESULT_CHECKSUM_EN.
- Backpressure: out_ready toggling 1,0,1,0 -> no duplicated or skipped lanes; fields stable while stalled; total 16 transfers.
- Overflow: out_ready=0, FIFO_DEPTH=4, five consecutive result_valid -> almost_full high after the 3rd; overflow set on the 5th; only 4 vectors drain afterwards.
- Full with simultaneous pop: FIFO full, last-lane handshake in the same cycle as result_valid -> push accepted; overflow stays 0.
- Streaming: expected=256, one vector every 16 cycles, out_ready=1 -> zero gaps, vec_count=256, done exactly once, no overflow.
- Restart: start asserted mid-drain of vector 3 of 8 -> out_valid drops the next cycle; vec_count=0; a new run with expected=2 completes normally.

Source files
------------

// File: rtl/rftpu_result_drain.sv
// Result drain: buffers systolic-array result vectors and serializes them lane by lane.
// Optional RESULT_CHECKSUM_EN adds a running sum of every transferred beat.
`timescale 1ns/1ps
module rftpu_result_drain #(
  parameter int ARRAY_DIM  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [15:0]                    expected_vectors,
  input  logic                           result_valid,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0] result_data,
  output logic                           almost_full,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           out_data,
  output logic [$clog2(ARRAY_DIM)-1:0]   out_lane,
  output logic                           out_last,
  output logic [15:0]                    vec_count,
  output logic                           overflow,
  output logic                           done,
  output logic [ACC_WIDTH-1:0]           checksum
);

  // state  | meaning
  // S_IDLE | after reset, results ignored
  // S_RUN  | capturing and draining vectors
  // S_DONE | expected count drained, extra results flag overflow
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int LANE_W = $clog2(ARRAY_DIM);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int VEC_W  = ARRAY_DIM * ACC_WIDTH;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [15:0]        vec_count_q, vec_count_d, vec_count_inc, exp_q;
  logic               ovf_q, ovf_d, done_q, done_d, af_q;
  logic               fifo_full, last_lane, beat, pop, push, drop;
  logic [VEC_W-1:0]   head;

  assign head          = mem_q[rd_ptr_q];
  assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign last_lane     = (lane_q == LANE_W'(ARRAY_DIM - 1));
  assign beat          = out_valid && out_ready;
  assign pop           = beat && last_lane;
  assign vec_count_inc = (vec_count_q == 16'hFFFF) ? vec_count_q : vec_count_q + 16'd1;

  // start discards any result arriving in the same cycle
  assign push = !start && result_valid && (state_q == S_RUN) && (!fifo_full || pop);
  assign drop = !start && result_valid &&
                (((state_q == S_RUN) && fifo_full && !pop) || (state_q == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = (expected_vectors == 16'd0) ? S_DONE : S_RUN;
      done_d  = (expected_vectors == 16'd0);
    end else begin
      case (state_q)
        S_RUN: begin
          if (pop && (vec_count_inc == exp_q)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == S_RUN) && (count_q != '0);
    out_lane  = lane_q;
    out_last  = out_valid && last_lane;
    out_data  = out_valid ? head[int'(lane_q)*ACC_WIDTH +: ACC_WIDTH] : '0;
  end

  always_comb begin
    if (start) begin
      count_d     = '0;
      lane_d      = '0;
      vec_count_d = '0;
      ovf_d       = 1'b0;
    end else begin
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      lane_d      = beat ? (last_lane ? '0 : lane_q + LANE_W'(1)) : lane_q;
      vec_count_d = pop ? vec_count_inc : vec_count_q;
      ovf_d       = ovf_q | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lane_q      <= '0;
      vec_count_q <= '0;
      exp_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      af_q        <= 1'b0;
    end else begin
      count_q     <= count_d;
      lane_q      <= lane_d;
      vec_count_q <= vec_count_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      af_q        <= (count_d >= CNT_W'(FIFO_DEPTH - 1));
      if (start) begin
        exp_q    <= expected_vectors;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= result_data;
  end

`ifdef RESULT_CHECKSUM_EN
  logic [ACC_WIDTH-1:0] csum_q;
  always_ff @(posedge clk) begin
    if (rst || start) csum_q <= '0;
    else if (beat)    csum_q <= csum_q + out_data;
  end
  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

  assign almost_full = af_q;
  assign vec_count   = vec_count_q;
  assign overflow    = ovf_q;
  assign done        = done_q;

endmodule

// File: tb/tb_rftpu_result_drain.sv
// Randomized bench for rftpu_result_drain against a queue-based reference model.
`timescale 1ns/1ps
module tb_rftpu_result_drain;
  localparam int AD = 16;
  localparam int AW = 32;
  localparam int FD = 4;
  localparam int VW = AD * AW;

  logic          clk = 1'b0;
  logic          rst, start, result_valid, out_ready;
  logic [15:0]   expected_vectors;
  logic [VW-1:0] result_data;
  logic          almost_full, out_valid, out_last, overflow, done;
  logic [AW-1:0] out_data, checksum;
  logic [3:0]    out_lane;
  logic [15:0]   vec_count;

  always #5 clk = ~clk;

  rftpu_result_drain #(.ARRAY_DIM(AD), .ACC_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .expected_vectors(expected_vectors),
    .result_valid(result_valid), .result_data(result_data), .almost_full(almost_full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
    .out_last(out_last), .vec_count(vec_count), .overflow(overflow), .done(done),
    .checksum(checksum)
  );

  int n_chk = 0, n_pass = 0;
  int n_done_obs = 0, n_beats_obs = 0;

  // reference model: 0 idle, 1 run, 2 done; vectors held in a queue
  int            m_state = 0;
  logic [VW-1:0] m_q[$];
  int            m_lane = 0;
  int            m_vcnt = 0;
  int            m_exp = 0;
  logic          m_ovf = 1'b0, m_done = 1'b0, m_af = 1'b0;
  logic [AW-1:0] m_csum = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    logic          v;
    logic [VW-1:0] h;
    logic [AW-1:0] d;
    logic [AW-1:0] cs;
    v = (m_state == 1) && (m_q.size() > 0);
    d = '0;
    if (v) begin
      h = m_q[0];
      d = h[m_lane*AW +: AW];
    end
`ifdef RESULT_CHECKSUM_EN
    cs = m_csum;
`else
    cs = '0;
`endif
    chk("out_valid", out_valid, v);
    chk("out_data", out_data, d);
    chk("out_lane", out_lane, m_lane);
    chk("out_last", out_last, v && (m_lane == AD-1));
    chk("vec_count", vec_count, m_vcnt);
    chk("overflow", overflow, m_ovf);
    chk("done", done, m_done);
    chk("almost_full", almost_full, m_af);
    chk("checksum", checksum, cs);
    if (done) n_done_obs++;
    if (out_valid && out_ready) n_beats_obs++;
  endtask

  task automatic model_step();
    logic          v, beat, pop;
    int            sz, st;
    logic [VW-1:0] h;
    v    = (m_state == 1) && (m_q.size() > 0);
    beat = v && out_ready;
    pop  = beat && (m_lane == AD-1);
    sz   = m_q.size();
    st   = m_state;
    if (rst) begin
      m_state = 0; m_q.delete(); m_lane = 0; m_vcnt = 0; m_exp = 0;
      m_ovf = 0; m_done = 0; m_af = 0; m_csum = '0;
    end else if (start) begin
      m_q.delete(); m_lane = 0; m_vcnt = 0; m_ovf = 0; m_csum = '0; m_af = 0;
      m_exp   = int'(expected_vectors);
      m_state = (m_exp == 0) ? 2 : 1;
      m_done  = (m_exp == 0);
    end else begin
      m_done = 0;
      if (beat) begin
        h = m_q[0];
        m_csum = m_csum + h[m_lane*AW +: AW];
        if (pop) begin
          void'(m_q.pop_front());
          m_lane = 0;
          if (m_vcnt < 65535) m_vcnt++;
          if (m_vcnt == m_exp) begin
            m_state = 2;
            m_done  = 1;
          end
        end else begin
          m_lane++;
        end
      end
      if (result_valid) begin
        if (st == 1 && (sz < FD || pop)) m_q.push_back(result_data);
        else if (st != 0) m_ovf = 1;
      end
      m_af = (m_q.size() >= FD-1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    expected_vectors = 16'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic rand_vec(output logic [VW-1:0] v);
    for (int k = 0; k < AD; k++) v[k*AW +: AW] = $urandom;
  endtask

  task automatic push_vec(input logic [VW-1:0] v);
    result_valid = 1'b1;
    result_data  = v;
    tick();
    result_valid = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] v;
    int            n;
    rst = 1'b1; start = 1'b0; result_valid = 1'b0; out_ready = 1'b0;
    expected_vectors = '0; result_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // basic drain, lane k carries k+1
    do_start(1);
    for (int k = 0; k < AD; k++) v[k*AW +: AW] = 32'(k + 1);
    n_beats_obs = 0; n_done_obs = 0;
    push_vec(v);
    out_ready = 1'b1;
    repeat (20) tick();
    chk("basic_vec_count", vec_count, 1);
    chk("basic_beats", n_beats_obs, AD);
    chk("basic_done_once", n_done_obs, 1);
`ifdef RESULT_CHECKSUM_EN
    chk("basic_checksum", checksum, 136);
`endif

    // backpressure, ready toggling
    do_start(1);
    rand_vec(v);
    n_beats_obs = 0;
    out_ready = 1'b0;
    push_vec(v);
    for (int i = 0; i < 40; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    chk("bp_beats", n_beats_obs, AD);

    // overflow with ready low
    out_ready = 1'b0;
    do_start(8);
    for (int i = 0; i < 5; i++) begin
      rand_vec(v);
      push_vec(v);
      if (i == 2) chk("ovf_af_after3", almost_full, 1);
      if (i == 3) chk("ovf_clear_after4", overflow, 0);
    end
    chk("ovf_set_after5", overflow, 1);
    out_ready = 1'b1;
    repeat (80) tick();
    chk("ovf_only4", vec_count, 4);

    // full FIFO with a push coinciding with the last-lane pop
    out_ready = 1'b0;
    do_start(8);
    for (int i = 0; i < 4; i++) begin
      rand_vec(v);
      push_vec(v);
    end
    out_ready = 1'b1;
    n = 0;
    while (m_lane != AD-1 && n < 40) begin
      tick();
      n++;
    end
    chk("simul_reach_last", n < 40, 1);
    rand_vec(v);
    push_vec(v);
    chk("simul_no_ovf", overflow, 0);
    chk("simul_af", almost_full, 1);
    repeat (90) tick();
    chk("simul_vec_count", vec_count, 5);

    // streaming, one vector every AD cycles
    do_start(256);
    n_done_obs = 0; n_beats_obs = 0;
    for (int i = 0; i < 256; i++) begin
      rand_vec(v);
      push_vec(v);
      repeat (AD-1) tick();
    end
    repeat (20) tick();
    chk("stream_vec_count", vec_count, 256);
    chk("stream_done_once", n_done_obs, 1);
    chk("stream_beats", n_beats_obs, 256*AD);
    chk("stream_no_ovf", overflow, 0);

    // restart mid-drain of vector 3
    do_start(8);
    for (int i = 0; i < 3; i++) begin
      rand_vec(v);
      push_vec(v);
      if (i < 2) repeat (AD-1) tick();
    end
    repeat (5) tick();
    rand_vec(v);
    result_valid = 1'b1; result_data = v;
    start = 1'b1; expected_vectors = 16'd2;
    tick();
    start = 1'b0; result_valid = 1'b0;
    chk("restart_valid_low", out_valid, 0);
    chk("restart_vec_count", vec_count, 0);
    n_done_obs = 0;
    for (int i = 0; i < 2; i++) begin
      rand_vec(v);
      push_vec(v);
    end
    repeat (40) tick();
    chk("restart_vec_count2", vec_count, 2);
    chk("restart_done_once", n_done_obs, 1);

    // random traffic
    for (int r = 0; r < 30; r++) begin
      do_start($urandom_range(0, 6));
      for (int c = 0; c < 150; c++) begin
        result_valid = ($urandom_range(0, 3) == 0);
        rand_vec(v);
        result_data = v;
        out_ready = ($urandom_range(0, 3) != 0);
        rst   = ($urandom_range(0, 499) == 0);
        start = !rst && ($urandom_range(0, 299) == 0);
        expected_vectors = 16'($urandom_range(0, 5));
        tick();
        rst = 1'b0; start = 1'b0;
      end
    end
    result_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
